// File: rtl/memctrl_pkg.sv
// memctrl_pkg: state, size and port codes shared by the memory controller slice.
package memctrl_pkg;
    localparam logic [1:0] MC_IDLE  = 2'd0;
    localparam logic [1:0] MC_READ  = 2'd1;
    localparam logic [1:0] MC_WRITE = 2'd2;
    localparam logic [1:0] MC_REST  = 2'd3;
    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    typedef enum logic {MC_PORT_IF = 1'b0, MC_PORT_D = 1'b1} port_e;
    // Size code 3 falls through to a full word.
    function automatic logic [2:0] size_len(input logic [1:0] sz);
        return sz == SZ_BYTE ? 3'd1 : sz == SZ_HALF ? 3'd2 : 3'd4;
    endfunction
endpackage

// File: rtl/memctrl_if.sv
// memctrl_if: fetch port, data port and byte-wide RAM bus of the memory controller.
interface memctrl_if #(parameter int ADDR_W = 32);
    logic              if_read;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ok;
    logic [31:0]       if_rtn;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [1:0]        d_size;
    logic [31:0]       d_wdata;
    logic              d_ok;
    logic [31:0]       d_rtn;
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;
    modport master (
        output if_read, if_addr, d_read, d_write, d_addr, d_size, d_wdata, mem_din,
        input  if_ok, if_rtn, d_ok, d_rtn, mem_dout, mem_a, mem_wr
    );
    modport slave (
        input  if_read, if_addr, d_read, d_write, d_addr, d_size, d_wdata, mem_din,
        output if_ok, if_rtn, d_ok, d_rtn, mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/memctrl.sv
// memctrl: arbitrates fetch and data requests and serialises them into byte
// transfers on a synchronous 8-bit RAM bus, one ok pulse per accepted request.
module memctrl
    import memctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input logic       clk,
    input logic       rst,
    input logic       rdy,
    memctrl_if.slave  bus
);
    logic [1:0]        r_state;
    logic [2:0]        r_cnt;
    logic [2:0]        r_len;
    port_e             r_port;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_mem_a;
    logic [31:0]       r_wdata;
    logic [31:0]       r_data;
    logic [31:0]       r_if_rtn;
    logic [31:0]       r_d_rtn;
    logic              r_if_ok;
    logic              r_d_ok;
    logic              r_mem_wr;
    logic [7:0]        r_mem_dout;
    logic              w_take_d;
    logic              w_req;
    logic [ADDR_W-1:0] w_req_addr;
    logic [ADDR_W-1:0] w_next_a;
    logic [31:0]       w_merged;
    // r_cnt is the index of the current edge since acceptance; byte r_cnt-2 arrives on mem_din now.
    always_comb begin
        w_take_d   = bus.d_read | bus.d_write;
        w_req      = w_take_d | bus.if_read;
        w_req_addr = w_take_d ? bus.d_addr : bus.if_addr;
        w_next_a   = r_addr + ADDR_W'(r_cnt);
        w_merged   = r_data | (32'(bus.mem_din) << {r_cnt - 3'd2, 3'b000});
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= MC_IDLE;
            r_cnt      <= '0;
            r_len      <= '0;
            r_port     <= MC_PORT_IF;
            r_addr     <= '0;
            r_mem_a    <= '0;
            r_wdata    <= '0;
            r_data     <= '0;
            r_if_rtn   <= '0;
            r_d_rtn    <= '0;
            r_if_ok    <= 1'b0;
            r_d_ok     <= 1'b0;
            r_mem_wr   <= 1'b0;
            r_mem_dout <= '0;
        end else if (rdy) begin
            case (r_state)
                MC_IDLE: if (w_req) begin
                    r_port     <= w_take_d ? MC_PORT_D : MC_PORT_IF;
                    r_addr     <= w_req_addr;
                    r_mem_a    <= w_req_addr;
                    r_len      <= w_take_d ? size_len(bus.d_size) : 3'd4;
                    r_wdata    <= bus.d_wdata;
                    r_data     <= '0;
                    r_cnt      <= 3'd1;
                    r_mem_wr   <= bus.d_write;
                    r_mem_dout <= bus.d_wdata[7:0];
                    r_state    <= bus.d_write ? MC_WRITE : MC_READ;
                end
                MC_READ: begin
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt < r_len)
                        r_mem_a <= w_next_a;
                    if (r_cnt == r_len + 3'd1) begin
                        if (r_port == MC_PORT_D) begin
                            r_d_rtn <= w_merged;
                            r_d_ok  <= 1'b1;
                        end else begin
                            r_if_rtn <= w_merged;
                            r_if_ok  <= 1'b1;
                        end
                        r_state <= MC_REST;
                    end else if (r_cnt >= 3'd2) begin
                        r_data <= w_merged;
                    end
                end
                MC_WRITE: if (r_cnt < r_len) begin
                    r_cnt      <= r_cnt + 3'd1;
                    r_mem_a    <= w_next_a;
                    r_mem_dout <= 8'(r_wdata >> {r_cnt, 3'b000});
                end else begin
                    r_mem_wr <= 1'b0;
                    r_d_ok   <= 1'b1;
                    r_state  <= MC_REST;
                end
                default: begin
                    r_if_ok <= 1'b0;
                    r_d_ok  <= 1'b0;
                    r_state <= MC_IDLE;
                end
            endcase
        end
    end
    assign bus.if_ok    = r_if_ok;
    assign bus.if_rtn   = r_if_rtn;
    assign bus.d_ok     = r_d_ok;
    assign bus.d_rtn    = r_d_rtn;
    assign bus.mem_a    = r_mem_a;
    assign bus.mem_wr   = r_mem_wr;
    assign bus.mem_dout = r_mem_dout;
endmodule

// File: tb/tb_memctrl.sv
// tb_memctrl: drives fetch/data requests against a byte RAM model and checks
// results, latencies and bus activity against a reference memory map.
module tb_memctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    memctrl_if #(.ADDR_W(32)) bus();
    memctrl #(.ADDR_W(32)) dut (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus));
    always #5 clk = ~clk;
    logic [7:0]  ram     [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];
    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] exp_d_rtn = '0;
    logic [31:0] exp_if_rtn = '0;
    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction
    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction
    // The RAM sits on the same global enable as the controller.
    always @(posedge clk) if (rdy) begin
        bus.mem_din <= ram_rd(bus.mem_a);
        if (bus.mem_wr) ram[bus.mem_a] = bus.mem_dout;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic poke(input logic [31:0] a, input logic [7:0] v);
        ram[a] = v;
        ref_mem[a] = v;
    endtask
    function automatic int len_of(input logic [1:0] sz);
        return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
    endfunction
    // Latencies count enabled edges from raising the request; a served fetch waits for the data access plus its rest cycle.
    task automatic run(input bit den, input bit dwr, input logic [31:0] da, input logic [1:0] dsz,
                       input logic [31:0] dwd, input bit fen, input logic [31:0] fa, input int gap_at);
        int dlen, dlat, flat, fst, act, gap, dseen, fseen, de, fe, dok_n, fok_n, wr_n, span, frz;
        bit r;
        dlen = len_of(dsz);
        dlat = dwr ? dlen + 1 : dlen + 2;
        fst  = den ? dlat + 1 : 0;
        flat = fst + 6;
        act = 0; gap = 0; dseen = -1; fseen = -1; de = -1; fe = -1;
        dok_n = 0; fok_n = 0; wr_n = 0;
        frz = gap_at > 0 ? 3 : 0;
        if (den && dwr)
            for (int k = 0; k < dlen; k++) ref_mem[da + 32'(k)] = 8'(dwd >> (8 * k));
        if (den && !dwr) begin
            exp_d_rtn = '0;
            for (int k = 0; k < dlen; k++) exp_d_rtn |= 32'(ref_rd(da + 32'(k))) << (8 * k);
        end
        if (fen) begin
            exp_if_rtn = '0;
            for (int k = 0; k < 4; k++) exp_if_rtn |= 32'(ref_rd(fa + 32'(k))) << (8 * k);
        end
        bus.d_read  = den && !dwr;
        bus.d_write = den && dwr;
        bus.d_addr  = da;
        bus.d_size  = dsz;
        bus.d_wdata = dwd;
        bus.if_read = fen;
        bus.if_addr = fa;
        span = (fen ? flat : den ? dlat : 2) + frz + 6;
        for (int e = 1; e <= span; e++) begin
            r = rdy;
            @(posedge clk); #1;
            if (r) act++;
            if (e == gap_at) begin
                rdy = 1'b0;
                gap = 3;
            end else if (gap > 0) begin
                gap--;
                if (gap == 0) rdy = 1'b1;
            end
            if (!r) continue;
            if (bus.d_ok) begin
                dok_n++;
                if (dseen < 0) begin dseen = act; de = e; end
                bus.d_read = 1'b0;
                bus.d_write = 1'b0;
            end
            if (bus.if_ok) begin
                fok_n++;
                if (fseen < 0) begin fseen = act; fe = e; end
                bus.if_read = 1'b0;
            end
            if (bus.mem_wr) begin
                check("wr_addr", bus.mem_a, da + 32'(wr_n));
                check("wr_byte", 32'(bus.mem_dout), 32'(8'(dwd >> (8 * wr_n))));
                wr_n++;
            end
            if (den && act >= 1 && act <= dlen) check("d_mem_a", bus.mem_a, da + 32'(act - 1));
            if (fen && act > fst && act <= fst + 4) check("f_mem_a", bus.mem_a, fa + 32'(act - fst - 1));
        end
        check("d_ok_count", dok_n, den ? 1 : 0);
        check("if_ok_count", fok_n, fen ? 1 : 0);
        if (den) check("d_latency", dseen, dlat);
        if (den) check("d_edges", de, dlat + (gap_at > 0 && gap_at < dlat ? 3 : 0));
        if (fen) check("if_latency", fseen, flat);
        if (fen) check("if_edges", fe, flat + (gap_at > 0 && gap_at < flat ? 3 : 0));
        check("wr_cycles", wr_n, (den && dwr) ? dlen : 0);
        check("d_rtn", bus.d_rtn, exp_d_rtn);
        check("if_rtn", bus.if_rtn, exp_if_rtn);
    endtask
    initial begin
        bus.if_read = 1'b0; bus.if_addr = '0;
        bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_size = '0; bus.d_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_if_ok", 32'(bus.if_ok), 0);
        check("rst_d_ok", 32'(bus.d_ok), 0);
        check("rst_if_rtn", bus.if_rtn, 0);
        check("rst_d_rtn", bus.d_rtn, 0);
        check("rst_mem_a", bus.mem_a, 0);
        check("rst_mem_dout", 32'(bus.mem_dout), 0);
        check("rst_mem_wr", 32'(bus.mem_wr), 0);
        rst = 1'b0;
        poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h00); poke(32'h103, 8'h00);
        run(0, 0, 0, 0, 0, 1, 32'h100, 0);
        check("fetch_word", exp_if_rtn, 32'h0000_0513);
        run(1, 1, 32'h2000, 2'd2, 32'hDEAD_BEEF, 0, 0, 0);
        run(1, 0, 32'h2003, 2'd0, 0, 0, 0, 0);
        check("byte_read_val", bus.d_rtn, 32'h0000_00DE);
        run(1, 0, 32'h2000, 2'd2, 0, 1, 32'h100, 0);
        poke(32'hFFFF_FFFF, 8'h34); poke(32'h0, 8'h12);
        run(1, 0, 32'hFFFF_FFFF, 2'd1, 0, 0, 0, 0);
        check("wrap_half", bus.d_rtn, 32'h0000_1234);
        run(0, 0, 0, 0, 0, 1, 32'h100, 3);
        run(0, 0, 0, 0, 0, 0, 0, 0);
        poke(32'h3000, 8'h11); poke(32'h3001, 8'h22); poke(32'h3002, 8'h77); poke(32'h3003, 8'h66);
        bus.d_write = 1'b1; bus.d_addr = 32'h3000; bus.d_size = 2'd2; bus.d_wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        check("rstw_wr_on", 32'(bus.mem_wr), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstw_wr_off", 32'(bus.mem_wr), 0);
        check("rstw_d_ok", 32'(bus.d_ok), 0);
        check("rstw_mem_a", bus.mem_a, 0);
        check("rstw_d_rtn", bus.d_rtn, 0);
        rst = 1'b0;
        bus.d_write = 1'b0;
        ref_mem[32'h3000] = 8'h0D;
        ref_mem[32'h3001] = 8'hF0;
        exp_d_rtn = '0;
        exp_if_rtn = '0;
        repeat (3) begin
            @(posedge clk); #1;
            check("rstw_no_ok", 32'(bus.d_ok), 0);
        end
        run(0, 0, 0, 0, 0, 1, 32'h3000, 0);
        check("rstw_partial", bus.if_rtn, 32'h6677_F00D);
        for (int i = 0; i < 40; i++) begin
            bit den, fen, dwr;
            logic [31:0] da, fa;
            den = ($urandom % 3) != 0;
            fen = !den || ($urandom % 2) != 0;
            dwr = ($urandom % 2) != 0;
            da  = (i % 8 == 0) ? 32'hFFFF_FFFD + 32'($urandom % 3) : 32'h4000 + 32'($urandom % 24);
            fa  = 32'h4000 + 32'($urandom % 24);
            run(den, dwr, da, 2'($urandom % 4), $urandom, fen, fa, (i % 5 == 4) ? 1 + int'($urandom % 5) : 0);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/memctrl.md
Name: memctrl

Overview:
- Memory controller; the responder end of the instruction-cache fetch handshake and of the load/store data handshake.
- Arbitrates between an instruction-fetch port (word reads only) and a data port (byte/half/word reads and writes).
- Serialises each access into byte transfers on the 8-bit synchronous RAM bus.
- Returns exactly one `*_ok` pulse per accepted request.

Parameters:
ADDR_W, 32, width of all addresses and of mem_a

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
rdy  in  1  global enable; 0 freezes all state
if_read  in  1  fetch request; held high until if_ok is seen
if_addr  in  ADDR_W  fetch address; stable while if_read is high
if_ok  out  1  one-cycle pulse; if_rtn is valid in that cycle
if_rtn  out  32  fetched word, little-endian
d_read  in  1  data read request; held until d_ok
d_write  in  1  data write request; held until d_ok; never high together with d_read
d_addr  in  ADDR_W  data address
d_size  in  2  0=byte, 1=half, 2=word; 3 is treated as word
d_wdata  in  32  write data; the low len bytes are used
d_ok  out  1  one-cycle completion pulse
d_rtn  out  32  read data, zero-extended; sign extension belongs to the LSU
mem_din  in  8  RAM read byte
mem_dout  out  8  RAM write byte
mem_a  out  ADDR_W  RAM byte address
mem_wr  out  1  RAM write enable, 1=write

Behaviour:
- RAM model: synchronous. The address driven during cycle N yields mem_din in cycle N+1. A write occurs at the edge ending the cycle in which mem_wr=1.
- All outputs are registered.
- Reset values: if_ok=0, d_ok=0, if_rtn=0, d_rtn=0, mem_a=0, mem_dout=0, mem_wr=0, state=IDLE, counters=0.
- Reset mid-operation abandons the access. No ok pulse is issued. A partially written word stays partially written.
- rdy=0: nothing changes; outputs hold their values.
- States:
  - IDLE: at an edge with rdy=1, select a request. Priority order is d_write, then d_read, then if_read. With no request, remain in IDLE with mem_wr=0.
  - Accepting latches addr, len (1/2/4; fetch=4), port, wdata. It sets mem_a<=addr at that edge (E0).
  - READ: at edge Ek (k=1..len-1), mem_a<=addr+k. At edge E(k+2), mem_din is captured into byte k of the result. The last byte is merged directly from mem_din at E(len+1), which is also when the port rtn gets the full zero-extended value and ok<=1. State then goes to REST. Word read: ok is high in the cycle after E5, i.e. 5 cycles after acceptance; byte read: 2 cycles.
  - WRITE: at E0, mem_wr<=1 and mem_dout<=wdata[7:0]. At Ek (k<len), mem_a<=addr+k and mem_dout<=wdata[8k+7:8k]. At E(len), mem_wr<=0, d_ok<=1, and state goes to REST. Word write: 4 cycles.
  - REST: ok<=0; go to IDLE at the next edge. No request is sampled here, because the requester drops its request at the edge on which it sees ok.
- ok pulses are exactly one cycle. The rtn registers hold their value until the next completion on the same port.
- Address arithmetic is addr+k modulo 2^ADDR_W, so a wrap from 0xFFFFFFFF to 0 is legal. Misaligned addresses are legal, since every access is byte-wise.
- A request that arrives while busy on the other port waits; requests are held by protocol, so none are lost. A fetch is starved only while data requests arrive back-to-back.
- d_rtn is not modified by fetches, and if_rtn is not modified by data accesses.

Decomposition:
- const.v additions:
  - `MC_IDLE/`MC_READ/`MC_WRITE/`MC_REST state codes (2 bits)
  - `SZ_BYTE/`SZ_HALF/`SZ_WORD size codes
  - `MC_PORT_IF/`MC_PORT_D
- A single module is natural. Counter, state register and byte assembly are small enough that no sub-module is warranted.

Test Plan:
- Fetch: RAM[0x100..0x103]=13,05,00,00 and if_read=1, if_addr=0x100 → mem_a steps 0x100..0x103; if_ok is high exactly one cycle, 5 cycles after acceptance, with if_rtn=0x00000513; d_ok stays 0.
- Write then read: d_write, d_size=2, d_addr=0x2000, d_wdata=0xDEADBEEF → mem_wr high 4 cycles, bytes EF,BE,AD,DE; d_ok at cycle 4. Then d_read, byte size, at 0x2003 → d_rtn=0x000000DE.
- Simultaneous if_read and d_read in IDLE → the data read is served first. The fetch starts only after the REST cycle, and if_ok comes exactly once.
- Half read at 0xFFFFFFFF with RAM[0xFFFFFFFF]=0x34 and RAM[0]=0x12 → mem_a goes 0xFFFFFFFF then 0x00000000; d_rtn=0x00001234.
- rdy held low for 3 cycles mid word-read → outputs frozen. Completion is delayed by exactly 3 cycles and the data is correct.
- rst asserted during the 2nd cycle of a word write → next cycle mem_wr=0, state IDLE, no d_ok; the following fetch completes normally.
